// File: rtl/dm_store_unit_if.sv
// Memory-stage store/load bus between the pipeline and dm_store_unit.
// Inputs come from the M stage; outputs are the registered M/W bundle.
interface dm_store_unit_if;
   logic        valid;
   logic        stall;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  StoreBE;
   logic [31:0] RD4out;
   logic [1:0]  byte_out;
   logic        ades;
   logic [3:0]  be_out;

   modport master (
      output valid, stall, addr, wdata, StoreBE,
      input  RD4out, byte_out, ades, be_out
   );

   modport slave (
      input  valid, stall, addr, wdata, StoreBE,
      output RD4out, byte_out, ades, be_out
   );
endinterface

// File: rtl/dm_store_unit.sv
// Data memory with byte-lane store alignment and a write-first
// registered read word handed to the WB load extender.
module dm_store_unit #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   dm_store_unit_if.slave  bus
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   rel;
   logic [1:0]    off;
   logic [IW-1:0] idx;
   logic          in_range;
   logic [3:0]    be_raw;
   logic          misalign;
   logic          err;
   logic [3:0]    be_app;
   logic [31:0]   wr_word;
   logic [31:0]   old_word;
   logic [31:0]   merged;
   logic          commit;
   logic [1:0]    unused_rel;

   assign rel        = bus.addr - BASE_ADDR;
   assign off        = bus.addr[1:0];
   assign idx        = rel[IW+1:2];
   assign unused_rel = rel[1:0];
   assign in_range   = (rel >> 2) < 32'(DEPTH_WORDS);

   always_comb begin
      be_raw   = 4'b0000;
      wr_word  = bus.wdata;
      misalign = 1'b0;
      unique case (bus.StoreBE)
         2'b01: begin
            be_raw   = 4'b1111;
            misalign = (off != 2'b00);
         end
         2'b10: begin
            be_raw   = off[1] ? 4'b1100 : 4'b0011;
            wr_word  = {2{bus.wdata[15:0]}};
            misalign = off[0];
         end
         2'b11: begin
            be_raw   = 4'b0001 << off;
            wr_word  = {4{bus.wdata[7:0]}};
         end
         default: be_raw = 4'b0000;
      endcase
   end

   // Out-of-range only counts as an error for an actual store.
   assign err    = misalign | (!in_range && bus.StoreBE != 2'b00);
   assign be_app = (bus.valid && !err) ? be_raw : 4'b0000;
   assign commit = bus.valid && !bus.stall;

   assign old_word = in_range ? mem[idx] : 32'h0;

   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be_app[i]) merged[8*i +: 8] = wr_word[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
         bus.RD4out   <= 32'h0;
         bus.byte_out <= 2'b00;
         bus.ades     <= 1'b0;
         bus.be_out   <= 4'b0000;
      end else if (!bus.stall) begin
         if (commit) begin
            for (int i = 0; i < 4; i++) begin
               if (be_app[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
         end
         bus.RD4out   <= merged;
         bus.byte_out <= off;
         bus.ades     <= bus.valid & err;
         bus.be_out   <= be_app;
      end
   end

endmodule

// File: tb/tb_dm_store_unit.sv
// Directed self-checking bench for dm_store_unit.
module tb_dm_store_unit;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   dm_store_unit_if bus ();

   dm_store_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic st,
                        input logic [1:0] be,
                        input logic [31:0] a,
                        input logic [31:0] d);
      bus.valid   = v;
      bus.stall   = st;
      bus.StoreBE = be;
      bus.addr    = a;
      bus.wdata   = d;
      step();
   endtask

   task automatic outs(input string tag,
                       input logic [31:0] rd,
                       input logic [1:0] bo,
                       input logic ad,
                       input logic [3:0] be);
      check({tag, ".rd"},   bus.RD4out, rd);
      check({tag, ".byte"}, 32'(bus.byte_out), 32'(bo));
      check({tag, ".ades"}, 32'(bus.ades), 32'(ad));
      check({tag, ".be"},   32'(bus.be_out), 32'(be));
   endtask

   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] SW   = 2'b01;
   localparam logic [1:0] SH   = 2'b10;
   localparam logic [1:0] SB   = 2'b11;

   initial begin
      reset = 1'b1;
      bus.valid = 1'b0; bus.stall = 1'b0; bus.StoreBE = NONE;
      bus.addr = 32'h40; bus.wdata = 32'h0;
      step();
      outs("reset", 32'h0, 2'd0, 1'b0, 4'h0);
      reset = 1'b0;
      drive(1, 0, NONE, 32'h40, 32'h0);
      outs("rd40", 32'h0, 2'd0, 1'b0, 4'h0);

      drive(1, 0, SW, 32'h10, 32'h11223344);
      outs("sw10", 32'h11223344, 2'd0, 1'b0, 4'hF);
      drive(1, 0, NONE, 32'h10, 32'h0);
      outs("rd10", 32'h11223344, 2'd0, 1'b0, 4'h0);

      drive(1, 0, SB, 32'h12, 32'hFFFFFFAB);
      outs("sb12", 32'h11AB3344, 2'd2, 1'b0, 4'h4);

      // bubble carrying a store must not write
      drive(0, 0, SB, 32'h12, 32'h000000CC);
      outs("bub12", 32'h11AB3344, 2'd2, 1'b0, 4'h0);
      drive(0, 0, SW, 32'h11, 32'h0);
      outs("bubmis", 32'h11AB3344, 2'd1, 1'b0, 4'h0);
      drive(1, 0, NONE, 32'h10, 32'h0);
      outs("rd10b", 32'h11AB3344, 2'd0, 1'b0, 4'h0);

      drive(1, 0, SW, 32'h1C, 32'h0);
      outs("clr1c", 32'h0, 2'd0, 1'b0, 4'hF);
      drive(1, 0, SH, 32'h1E, 32'h1234BEEF);
      outs("sh1e", 32'hBEEF0000, 2'd2, 1'b0, 4'hC);
      drive(1, 0, SH, 32'h1D, 32'h00005555);
      outs("sh1d", 32'hBEEF0000, 2'd1, 1'b1, 4'h0);
      drive(1, 0, SH, 32'h1C, 32'hAAAA7777);
      outs("sh1c", 32'hBEEF7777, 2'd0, 1'b0, 4'h3);

      drive(1, 0, SW, 32'h21, 32'hFFFFFFFF);
      outs("sw21", 32'h0, 2'd1, 1'b1, 4'h0);
      drive(1, 0, NONE, 32'h20, 32'h0);
      outs("rd20", 32'h0, 2'd0, 1'b0, 4'h0);

      drive(1, 0, NONE, 32'h13, 32'h0);
      outs("rd13", 32'h11AB3344, 2'd3, 1'b0, 4'h0);
      // stalled store then withdrawn: nothing lands
      drive(1, 1, SB, 32'h34, 32'h00000077);
      outs("stw1", 32'h11AB3344, 2'd3, 1'b0, 4'h0);
      drive(1, 1, SB, 32'h34, 32'h00000077);
      drive(0, 0, NONE, 32'h34, 32'h0);
      outs("rd34", 32'h0, 2'd0, 1'b0, 4'h0);

      drive(1, 0, NONE, 32'h13, 32'h0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, SB, 32'h30, 32'h0000005A);
         outs($sformatf("stall%0d", i), 32'h11AB3344, 2'd3, 1'b0, 4'h0);
      end
      drive(1, 0, SB, 32'h30, 32'h0000005A);
      outs("sb30", 32'h0000005A, 2'd0, 1'b0, 4'h1);

      drive(1, 0, SW, 32'h4000, 32'hDEADBEEF);
      outs("oor", 32'h0, 2'd0, 1'b1, 4'h0);
      drive(1, 0, NONE, 32'h4000, 32'h0);
      outs("rdoor", 32'h0, 2'd0, 1'b0, 4'h0);
      drive(1, 0, NONE, 32'h0, 32'h0);
      outs("rd0", 32'h0, 2'd0, 1'b0, 4'h0);

      reset = 1'b1;
      drive(1, 1, SW, 32'h0, 32'hCAFEBABE);
      outs("rststall", 32'h0, 2'd0, 1'b0, 4'h0);
      reset = 1'b0;
      drive(1, 0, NONE, 32'h0, 32'h0);
      outs("rd0r", 32'h0, 2'd0, 1'b0, 4'h0);
      drive(1, 0, NONE, 32'h10, 32'h0);
      outs("rd10r", 32'h0, 2'd0, 1'b0, 4'h0);
      drive(1, 0, SW, 32'h4, 32'h01020304);
      outs("sw4", 32'h01020304, 2'd0, 1'b0, 4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
